// File: rtl/imm_encoder.sv
// ============================================================================
// Module   : imm_encoder
// Brief    : Packs 8-bit constants into 6-bit immediate fields: one field when
//            the value survives sign/zero extension, otherwise prefix + low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             CS,
    input  logic [7:0]       value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       imm,
    output logic             prefix,
    output logic             last,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ONE  = 2'd1;
    localparam logic [1:0] c_PFX  = 2'd2;
    localparam logic [1:0] c_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] c_OVF_MAX = {CNT_W{1'b1}};

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [5:0] r_low;
    logic       w_accept;
    logic       w_fit;
    logic       w_out_valid_nxt;
    logic [5:0] w_imm_nxt;
    logic       w_prefix_nxt;
    logic       w_last_nxt;

    assign in_ready = !rst && ((r_state == c_IDLE) ||
                               (((r_state == c_ONE) || (r_state == c_LOW)) && out_ready));
    assign w_accept = in_valid && in_ready;

    // The first field is emitted straight from the incoming value, so the fit
    // decision and the upper bits are consumed at accept; only value[5:0] is kept.
    assign w_fit = CS ? ((value[7] == value[6]) && (value[6] == value[5]))
                      : (value[7:6] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_fit ? c_ONE : c_PFX;
        end else begin
            case (r_state)
                c_IDLE:       w_state_nxt = c_IDLE;
                c_PFX:        w_state_nxt = out_ready ? c_LOW : c_PFX;
                c_ONE, c_LOW: w_state_nxt = out_ready ? c_IDLE : r_state;
                default:      w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out_valid_nxt = out_valid;
        w_imm_nxt       = imm;
        w_prefix_nxt    = prefix;
        w_last_nxt      = last;
        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            if (w_fit) begin
                w_imm_nxt    = value[5:0];
                w_prefix_nxt = 1'b0;
                w_last_nxt   = 1'b1;
            end else begin
                w_imm_nxt    = {4'b0000, value[7:6]};
                w_prefix_nxt = 1'b1;
                w_last_nxt   = 1'b0;
            end
        end else if (out_ready) begin
            case (r_state)
                c_PFX: begin
                    w_out_valid_nxt = 1'b1;
                    w_imm_nxt       = r_low;
                    w_prefix_nxt    = 1'b0;
                    w_last_nxt      = 1'b1;
                end
                c_ONE, c_LOW: w_out_valid_nxt = 1'b0;
                default:      w_out_valid_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            imm       <= 6'd0;
            prefix    <= 1'b0;
            last      <= 1'b0;
            r_low     <= 6'd0;
        end else begin
            out_valid <= w_out_valid_nxt;
            imm       <= w_imm_nxt;
            prefix    <= w_prefix_nxt;
            last      <= w_last_nxt;
            if (w_accept) begin
                r_low <= value[5:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (w_accept && !w_fit && (ovf_count != c_OVF_MAX)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module   : tb_imm_encoder
// Brief    : Directed self-checking bench for imm_encoder (CNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       cs;
    logic [7:0] value;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] imm;
    logic       prefix;
    logic       last;
    logic [1:0] ovf_count;

    int total = 0;
    int bad   = 0;
    int exp_ovf = 0;

    imm_encoder #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .CS        (cs),
        .value     (value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .prefix    (prefix),
        .last      (last),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one value for a single edge; caller guarantees in_ready is high.
    task automatic send(input logic c, input logic [7:0] v);
        in_valid = 1'b1;
        cs       = c;
        value    = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_ovf < 3 && !(c ? (v[7] == v[6] && v[6] == v[5]) : (v[7:6] == 2'b00)))
            exp_ovf++;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; cs = 1'b0; value = 8'h00; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        step(); step();
        total++;
        if ({out_valid, imm, prefix, last, ovf_count} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b imm=%h p=%b l=%b ovf=%0d want all 0",
                     out_valid, imm, prefix, last, ovf_count);
        end
        rst = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        exp_ovf = 0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send(1'b1, 8'hE5);
        total++;
        if ({out_valid, imm, prefix, last} !== {1'b1, 6'h25, 1'b0, 1'b1} || ovf_count !== 2'd0) begin
            bad++;
            $display("FAIL single_cs1_E5: got v=%b imm=%h p=%b l=%b ovf=%0d want v=1 imm=25 p=0 l=1 ovf=0",
                     out_valid, imm, prefix, last, ovf_count);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got v=%b want 0", out_valid); end
        send(1'b0, 8'h25);
        total++;
        if ({out_valid, imm, prefix, last} !== {1'b1, 6'h25, 1'b0, 1'b1} || ovf_count !== 2'd0) begin
            bad++;
            $display("FAIL single_cs0_25: got v=%b imm=%h p=%b l=%b ovf=%0d want v=1 imm=25 p=0 l=1 ovf=0",
                     out_valid, imm, prefix, last, ovf_count);
        end
        step();
    endtask

    task automatic test_split();
        out_ready = 1'b1;
        send(1'b0, 8'hE5);
        total++;
        if ({out_valid, imm, prefix, last} !== {1'b1, 6'h03, 1'b1, 1'b0} || ovf_count !== 2'd1) begin
            bad++;
            $display("FAIL split_prefix: got v=%b imm=%h p=%b l=%b ovf=%0d want v=1 imm=03 p=1 l=0 ovf=1",
                     out_valid, imm, prefix, last, ovf_count);
        end
        step();
        total++;
        if ({out_valid, imm, prefix, last} !== {1'b1, 6'h25, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL split_low: got v=%b imm=%h p=%b l=%b want v=1 imm=25 p=0 l=1",
                     out_valid, imm, prefix, last);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL split_drain: got v=%b want 0", out_valid); end
    endtask

    task automatic test_boundaries();
        logic [7:0] vals [4] = '{8'h1F, 8'h20, 8'hDF, 8'hE0};
        logic       fits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [5:0] pfx  [4] = '{6'h00, 6'h00, 6'h03, 6'h00};
        logic [5:0] low  [4] = '{6'h1F, 6'h20, 6'h1F, 6'h20};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, vals[i]);
            if (!fits[i]) begin
                total++;
                if ({out_valid, imm, prefix, last} !== {1'b1, pfx[i], 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL bound_prefix_%h: got v=%b imm=%h p=%b l=%b want v=1 imm=%h p=1 l=0",
                             vals[i], out_valid, imm, prefix, last, pfx[i]);
                end
                step();
            end
            total++;
            if ({out_valid, imm, prefix, last} !== {1'b1, low[i], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL bound_low_%h: got v=%b imm=%h p=%b l=%b want v=1 imm=%h p=0 l=1",
                         vals[i], out_valid, imm, prefix, last, low[i]);
            end
            step();
        end
        total++;
        if (ovf_count !== 2'(exp_ovf)) begin
            bad++;
            $display("FAIL bound_ovf: got %0d want %0d", ovf_count, exp_ovf);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(1'b0, 8'hE5);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid, imm, prefix, last, in_ready} !== {1'b1, 6'h03, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold_%0d: got v=%b imm=%h p=%b l=%b rdy=%b want v=1 imm=03 p=1 l=0 rdy=0",
                         i, out_valid, imm, prefix, last, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, imm, prefix, last, in_ready} !== {1'b1, 6'h25, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL bp_low: got v=%b imm=%h p=%b l=%b rdy=%b want v=1 imm=25 p=0 l=1 rdy=1",
                     out_valid, imm, prefix, last, in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_idle: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h01, 8'hFF, 8'h10, 8'hF0};
        logic [5:0] exps [4] = '{6'h01, 6'h3F, 6'h10, 6'h30};
        out_ready = 1'b1;
        cs        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            value    = vals[i];
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            total++;
            if ({out_valid, imm, prefix, last} !== {1'b1, exps[i], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL stream_field_%0d: got v=%b imm=%h p=%b l=%b want v=1 imm=%h p=0 l=1",
                         i, out_valid, imm, prefix, last, exps[i]);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || ovf_count !== 2'(exp_ovf)) begin
            bad++;
            $display("FAIL stream_end: got v=%b ovf=%0d want v=0 ovf=%0d", out_valid, ovf_count, exp_ovf);
        end
    endtask

    task automatic test_reset_in_low();
        out_ready = 1'b1;
        send(1'b0, 8'hC0);
        step();
        rst = 1'b1; #1;
        total++;
        if (out_valid !== 1'b0 || ovf_count !== 2'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_low_async: got v=%b ovf=%0d rdy=%b want v=0 ovf=0 rdy=0",
                     out_valid, ovf_count, in_ready);
        end
        exp_ovf = 0;
        step();
        rst = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_low_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 8'hFF);
            step();
            if (i == 1) begin
                total++;
                if (ovf_count !== 2'd2) begin bad++; $display("FAIL sat_mid: got %0d want 2", ovf_count); end
            end
        end
        step();
        total++;
        if (ovf_count !== 2'd3) begin bad++; $display("FAIL sat_final: got %0d want 3", ovf_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_reset_in_low();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
